// File: rtl/pwm_servo_decoder_pkg.sv
// pwm_servo_decoder_pkg
//   Shared definitions for the servo PWM path: the motor command encoding
//   (also used by the motor controller), the nominal pulse times in 10 ns
//   clock counts, decode thresholds derived from those times, and the
//   width-to-command classifier.
package pwm_servo_decoder_pkg;

  typedef enum logic [1:0] {
    MOTOR_CCW  = 2'd0,
    MOTOR_CW   = 2'd1,
    MOTOR_STOP = 2'd2
  } motor_ctl_state_t;

  // Nominal servo pulse times at 100 MHz.
  localparam int unsigned T_1P0_MS = 100000;
  localparam int unsigned T_1P2_MS = 120000;
  localparam int unsigned T_1P5_MS = 150000;
  localparam int unsigned T_1P7_MS = 170000;
  localparam int unsigned T_2P0_MS = 200000;

  // Legal window is the 1.0..2.0 ms range widened by half a millisecond on
  // each side; the command thresholds sit midway between nominal set points.
  localparam int unsigned DEF_MIN_PW  = T_1P0_MS / 2;                // 0.5 ms
  localparam int unsigned DEF_MAX_PW  = T_2P0_MS + T_1P0_MS / 2;     // 2.5 ms
  localparam int unsigned DEF_CCW_MAX = (T_1P2_MS + T_1P5_MS) / 2;   // 1.35 ms
  localparam int unsigned DEF_CW_MIN  = (T_1P5_MS + T_1P7_MS) / 2;   // 1.6 ms
  localparam int unsigned DEF_TIMEOUT = 11 * T_2P0_MS;               // 22 ms

  function automatic motor_ctl_state_t classify_width(
    input logic [31:0] width,
    input int unsigned ccw_max,
    input int unsigned cw_min
  );
    if (width <= ccw_max)     return MOTOR_CCW;
    else if (width >= cw_min) return MOTOR_CW;
    else                      return MOTOR_STOP;
  endfunction

endpackage

// File: rtl/pwm_servo_decoder_edge_sync.sv
// pwm_edge_sync
//   Two-flop synchronizer for the asynchronous PWM pin plus one register
//   for edge detection. Rise and fall see the same pipeline delay, so the
//   synchronized high time equals the pin high time in cycles.
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   pwm_in in   asynchronous PWM pin
//   level  out  synchronized level
//   rise   out  one-cycle strobe on a synchronized rising edge
//   fall   out  one-cycle strobe on a synchronized falling edge
module pwm_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Reset to high: a pin that is already high when reset releases then
  // produces no rising edge, so a pulse in progress can never be measured.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pwm_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/pwm_servo_decoder.sv
// pwm_servo_decoder
//   Measures the high time of a 50 Hz servo PWM line in clock counts,
//   decodes it into a motor command and flags malformed or missing pulses.
//   clk          in   100 MHz clock
//   reset        in   synchronous, active-high
//   pwm_in       in   asynchronous servo PWM input
//   valid        out  one-cycle strobe: new legal pulse decoded
//   pulse_width  out  high time of the last legal pulse, clock counts
//   cmd          out  motor command (CCW=0, CW=1, STOP=2)
//   err          out  one-cycle strobe: pulse too short or too long
//   alive        out  high while legal pulses arrive within TIMEOUT
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ARM        | wait for a low input; discards a partial pulse
//   WAIT_RISE  | idle low, wait for the next rising edge
//   MEASURE    | input high, width counter running
module pwm_servo_decoder
  import pwm_servo_decoder_pkg::*;
#(
  parameter int unsigned CNT_W   = 22,
  parameter int unsigned MIN_PW  = DEF_MIN_PW,
  parameter int unsigned MAX_PW  = DEF_MAX_PW,
  parameter int unsigned CCW_MAX = DEF_CCW_MAX,
  parameter int unsigned CW_MIN  = DEF_CW_MIN,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic             valid,
  output logic [CNT_W-1:0] pulse_width,
  output logic [1:0]       cmd,
  output logic             err,
  output logic             alive
);

  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PW);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PW);
  localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ARM       = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             level;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             load_width;
  logic             inc_width;
  logic             take_pulse;
  logic             pulse_err;
  logic             tmo_expire;
  motor_ctl_state_t cmd_q;

  pwm_edge_sync u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_ARM;
    else       state <= state_nxt;
  end

  // In MEASURE the input is high on every cycle without a fall, so a count
  // of MAX_PW with no fall means the width is about to become MAX_PW+1.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARM:       if (!level) state_nxt = ST_WAIT_RISE;
      ST_WAIT_RISE: if (rise)   state_nxt = ST_MEASURE;
      ST_MEASURE: begin
        if (fall)                    state_nxt = ST_WAIT_RISE;
        else if (width_cnt == MAX_C) state_nxt = ST_ARM;
      end
      default:                       state_nxt = ST_ARM;
    endcase
  end

  always_comb begin
    load_width = 1'b0;
    inc_width  = 1'b0;
    take_pulse = 1'b0;
    pulse_err  = 1'b0;
    case (state)
      ST_WAIT_RISE: load_width = rise;
      ST_MEASURE: begin
        if (fall) begin
          if (width_cnt >= MIN_C) take_pulse = 1'b1;
          else                    pulse_err  = 1'b1;
        end else begin
          inc_width = 1'b1;
          if (width_cnt == MAX_C) pulse_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counter reaches TIMEOUT on this edge unless a rise clears it first.
  assign tmo_expire = !rise && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      width_cnt   <= '0;
      tmo_cnt     <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
      pulse_width <= '0;
      cmd_q       <= MOTOR_STOP;
      alive       <= 1'b0;
    end else begin
      valid <= take_pulse;
      err   <= pulse_err;

      if (load_width)     width_cnt <= CNT_ONE;
      else if (inc_width) width_cnt <= width_cnt + CNT_ONE;

      if (rise)                 tmo_cnt <= '0;
      else if (tmo_cnt != TMO_C) tmo_cnt <= tmo_cnt + CNT_ONE;

      if (take_pulse) begin
        pulse_width <= width_cnt;
        cmd_q       <= classify_width(32'(width_cnt), CCW_MAX, CW_MIN);
        alive       <= 1'b1;
      end else if (tmo_expire) begin
        cmd_q <= MOTOR_STOP;
        alive <= 1'b0;
      end
    end
  end

  assign cmd = cmd_q;

endmodule

// File: tb/tb_pwm_servo_decoder.sv
// Bench for pwm_servo_decoder with timing constants scaled down by 1000
// (thresholds keep their ratios) so the whole run stays short.
module tb_pwm_servo_decoder;
  import pwm_servo_decoder_pkg::*;

  localparam int CNT_W   = 12;
  localparam int MIN_PW  = 50;
  localparam int MAX_PW  = 250;
  localparam int CCW_MAX = 135;
  localparam int CW_MIN  = 160;
  localparam int TIMEOUT = 2200;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pwm_in = 1'b0;
  logic             valid;
  logic             err;
  logic             alive;
  logic [CNT_W-1:0] pulse_width;
  logic [1:0]       cmd;

  typedef struct packed {
    logic [CNT_W-1:0] width;
    logic [1:0]       cmd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   valid_seen = 0;
  int   err_seen = 0;

  always #5 clk = ~clk;

  pwm_servo_decoder #(
    .CNT_W   (CNT_W),
    .MIN_PW  (MIN_PW),
    .MAX_PW  (MAX_PW),
    .CCW_MAX (CCW_MAX),
    .CW_MIN  (CW_MIN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .valid       (valid),
    .pulse_width (pulse_width),
    .cmd         (cmd),
    .err         (err),
    .alive       (alive)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_cmd(input int w);
    if (w <= CCW_MAX) return 2'd0;
    if (w >= CW_MIN)  return 2'd1;
    return 2'd2;
  endfunction

  task automatic push(input int w);
    exp_t e;
    e.width = CNT_W'(w);
    e.cmd   = ref_cmd(w);
    sb.push_back(e);
  endtask

  // Inputs change 1 ns after the rising edge; checks happen there too.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    pwm_in = 1'b1;
    tick(hi);
    pwm_in = 1'b0;
    tick(lo);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_pw"},    32'(pulse_width), 0);
    check({tag, "_cmd"},   32'(cmd), 2);
    check({tag, "_alive"}, 32'(alive), 0);
  endtask

  // Scoreboard side: every valid strobe must match the oldest pushed pulse.
  always @(negedge clk) begin
    if (valid || err) check("strobe_exclusive", 32'(valid & err), 0);
    if (err) err_seen++;
    if (valid) begin
      valid_seen++;
      check("valid_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("sb_width", 32'(pulse_width), 32'(mon_e.width));
        check("sb_cmd",   32'(cmd), 32'(mon_e.cmd));
        check("sb_alive", 32'(alive), 1);
      end
    end
  end

  initial begin
    int bw[6];
    logic [1:0] bc[6];
    int v0;
    int e0;
    int n;
    bw = '{135, 136, 159, 160, 50, 250};
    bc = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1};

    // Reset with the pin already high mid-pulse.
    reset = 1'b1;
    pwm_in = 1'b1;
    tick(3);
    check_reset_values("rst");
    reset = 1'b0;
    tick(60);
    pwm_in = 1'b0;
    tick(20);
    check("partial_no_valid", 32'(valid_seen), 0);
    check("partial_no_err",   32'(err_seen), 0);

    // First full pulse: valid appears 3 edges after the pin falls.
    push(170);
    pwm_in = 1'b1;
    tick(170);
    pwm_in = 1'b0;
    tick(2);
    check("t1_valid_before", 32'(valid), 0);
    tick(1);
    check("t1_valid",  32'(valid), 1);
    check("t1_width",  32'(pulse_width), 170);
    check("t1_cmd",    32'(cmd), 1);
    check("t1_alive",  32'(alive), 1);
    tick(1);
    check("t1_valid_after", 32'(valid), 0);
    tick(1800);
    check("t1_count", 32'(valid_seen), 1);

    // 20 ms frames: STOP then CCW.
    push(150);
    pulse(150, 1850);
    check("t2_count_a", 32'(valid_seen), 2);
    check("t2_cmd_a",   32'(cmd), 2);
    check("t2_width_a", 32'(pulse_width), 150);
    push(120);
    pulse(120, 1880);
    check("t2_count_b", 32'(valid_seen), 3);
    check("t2_cmd_b",   32'(cmd), 0);
    check("t2_width_b", 32'(pulse_width), 120);

    // Threshold and window boundaries.
    v0 = valid_seen;
    for (int i = 0; i < 6; i++) begin
      push(bw[i]);
      pulse(bw[i], 600);
      check("t3_count", 32'(valid_seen), 32'(v0 + i + 1));
      check("t3_cmd",   32'(cmd), 32'(bc[i]));
      check("t3_width", 32'(pulse_width), 32'(bw[i]));
    end

    // Short pulses: err only, outputs hold.
    v0 = valid_seen;
    e0 = err_seen;
    pulse(10, 300);
    check("t4_glitch_err",   32'(err_seen), 32'(e0 + 1));
    check("t4_glitch_valid", 32'(valid_seen), 32'(v0));
    check("t4_glitch_cmd",   32'(cmd), 1);
    check("t4_glitch_width", 32'(pulse_width), 250);
    pulse(MIN_PW - 1, 300);
    check("t4_short_err", 32'(err_seen), 32'(e0 + 2));

    // Stuck high: 2 sync edges, then err on the edge width reaches MAX_PW+1.
    pwm_in = 1'b1;
    n = 0;
    while (!err && n < 400) begin
      tick(1);
      n++;
    end
    check("t4_abort_latency", 32'(n), 32'(MAX_PW + 3));
    tick(100);
    pwm_in = 1'b0;
    tick(100);
    check("t4_abort_valid", 32'(valid_seen), 32'(v0));
    check("t4_abort_err",   32'(err_seen), 32'(e0 + 3));
    push(170);
    pulse(170, 300);
    check("t4_recover", 32'(valid_seen), 32'(v0 + 1));
    check("t4_recover_cmd", 32'(cmd), 1);

    // Loss of signal: counter reaches TIMEOUT on edge 3+TIMEOUT after the pin rise.
    push(120);
    pwm_in = 1'b1;
    tick(120);
    pwm_in = 1'b0;
    tick(TIMEOUT + 2 - 120);
    check("t5_alive_before", 32'(alive), 1);
    check("t5_cmd_before",   32'(cmd), 0);
    tick(1);
    check("t5_alive_after", 32'(alive), 0);
    check("t5_cmd_after",   32'(cmd), 2);
    check("t5_width_hold",  32'(pulse_width), 120);

    // Reset in the middle of a pulse.
    v0 = valid_seen;
    e0 = err_seen;
    pwm_in = 1'b1;
    tick(82);
    reset = 1'b1;
    tick(1);
    check_reset_values("t6");
    reset = 1'b0;
    tick(118);
    pwm_in = 1'b0;
    tick(300);
    check("t6_no_valid", 32'(valid_seen), 32'(v0));
    check("t6_no_err",   32'(err_seen), 32'(e0));
    push(170);
    pulse(170, 300);
    check("t6_next_valid", 32'(valid_seen), 32'(v0 + 1));
    check("t6_next_width", 32'(pulse_width), 170);
    check("t6_next_alive", 32'(alive), 1);
    check("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
